accum_bank: RTL and testbench

ACCUM_BANK -- requirements
Module: accum_bank

---
 rtl/accum_bank_pkg.sv | 23 ++
 rtl/accum_bank_if.sv | 30 +++
 rtl/accum_chan.sv | 86 ++++++++
 rtl/accum_bank.sv | 36 +++
 tb/tb_accum_bank.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/accum_bank_pkg.sv
// Shared definitions for the accumulator bank: addition mode encoding and
// the saturating increment used by the per-channel sample counters.
// No ports; imported by accum_chan and accum_bank.
package accum_bank_pkg;

  // Value carried on sat_mode.
  typedef enum logic {
    MODE_WRAP = 1'b0,  // modulo 2^WIDTH addition
    MODE_SAT  = 1'b1   // unsigned saturating addition
  } mode_e;

  // Counters are evaluated through a 32-bit helper, so CNT_W is capped here.
  localparam int CNT_W_MAX = 32;

  // Increment that sticks at cnt_max instead of wrapping.
  function automatic logic [CNT_W_MAX-1:0] cnt_sat_inc(
    input logic [CNT_W_MAX-1:0] cnt,
    input logic [CNT_W_MAX-1:0] cnt_max
  );
    return (cnt >= cnt_max) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/accum_bank_if.sv
// Bundles the per-channel control, sample and result vectors of accum_bank.
// master: sample source / result consumer; slave: the accumulator bank.
// Vectors are packed channel-major (channel c occupies [c*W +: W]).
interface accum_bank_if #(
  parameter int NCH   = 2,
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);

  logic                   sat_mode;
  logic [NCH-1:0]         in_valid;
  logic [NCH*WIDTH-1:0]   accum_in;
  logic [NCH-1:0]         clear;
  logic [NCH-1:0]         bypass;
  logic [NCH*WIDTH-1:0]   accum_out;
  logic [NCH*WIDTH-1:0]   bypass_out;
  logic [NCH-1:0]         ovf;
  logic [NCH*CNT_W-1:0]   count;

  modport master (
    output sat_mode, in_valid, accum_in, clear, bypass,
    input  accum_out, bypass_out, ovf, count
  );

  modport slave (
    input  sat_mode, in_valid, accum_in, clear, bypass,
    output accum_out, bypass_out, ovf, count
  );

endinterface

// File: rtl/accum_chan.sv
// One accumulator channel: accum += sample (wrap or saturate), sticky
// overflow flag and saturating accepted-sample counter.
// Latency: 1 cycle from accepted sample to accum_o/ovf_o/count_o; bypass_o is
// combinational. No backpressure: every valid sample is accepted.
// Ports: clk/rst_n; sat_mode_i; in_valid_i/accum_in_i sample; clear_i;
// bypass_i selects bypass_o source; accum_o, ovf_o, count_o registered.
module accum_chan
  import accum_bank_pkg::*;
#(
  parameter int WIDTH = 32,  // 1..129
  parameter int CNT_W = 8    // 1..CNT_W_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sat_mode_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] accum_in_i,
  input  logic             clear_i,
  input  logic             bypass_i,
  output logic [WIDTH-1:0] accum_o,
  output logic [WIDTH-1:0] bypass_o,
  output logic             ovf_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] accum_q, accum_d;
  logic             ovf_q,   ovf_d;
  logic [CNT_W-1:0] count_q, count_d;

  // One extra bit holds the carry; zero-extending both operands keeps the
  // top bit defined even when WIDTH is 1.
  logic [WIDTH:0] sum;
  logic           carry;

  assign sum   = {1'b0, accum_q} + {1'b0, accum_in_i};
  assign carry = sum[WIDTH];

  always_comb begin
    accum_d = accum_q;
    ovf_d   = ovf_q;
    count_d = count_q;

    if (clear_i) begin
      // Clear wins over the old state; a sample in the same cycle becomes
      // the first sample of the new run.
      if (in_valid_i) begin
        accum_d = accum_in_i;
        count_d = CNT_W'(1);
      end else begin
        accum_d = '0;
        count_d = '0;
      end
      ovf_d = 1'b0;
    end else if (in_valid_i) begin
      if (carry) begin
        ovf_d   = 1'b1;
        accum_d = (mode_e'(sat_mode_i) == MODE_SAT) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
      end else begin
        // Saturated all-ones plus zero has no carry and stays all-ones.
        accum_d = sum[WIDTH-1:0];
      end
      count_d = CNT_W'(cnt_sat_inc(32'(count_q), 32'(CNT_MAX)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accum_q <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      accum_q <= accum_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign accum_o  = accum_q;
  assign ovf_o    = ovf_q;
  assign count_o  = count_q;
  // accum_q is forced to zero by reset, so bypass_o reads 0 there unless bypassed.
  assign bypass_o = bypass_i ? accum_in_i : accum_q;

endmodule

// File: rtl/accum_bank.sv
// Bank of NCH independent accumulator channels behind one accum_bank_if.
// Latency: 1 cycle sample-to-result; bypass_out combinational.
// No backpressure: every valid sample is accepted on the edge it is presented.
// Ports: clk, rst_n (async active-low), bus (slave modport of accum_bank_if).
module accum_bank
  import accum_bank_pkg::*;
#(
  parameter int NCH   = 2,   // 1..16
  parameter int WIDTH = 32,  // 1..129
  parameter int CNT_W = 8    // 1..CNT_W_MAX
) (
  input  logic        clk,
  input  logic        rst_n,
  accum_bank_if.slave bus
);

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    accum_chan #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .sat_mode_i (bus.sat_mode),
      .in_valid_i (bus.in_valid[c]),
      .accum_in_i (bus.accum_in[c*WIDTH +: WIDTH]),
      .clear_i    (bus.clear[c]),
      .bypass_i   (bus.bypass[c]),
      .accum_o    (bus.accum_out[c*WIDTH +: WIDTH]),
      .bypass_o   (bus.bypass_out[c*WIDTH +: WIDTH]),
      .ovf_o      (bus.ovf[c]),
      .count_o    (bus.count[c*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_accum_bank.sv
// Bench for accum_bank: two instances (32-bit/8-bit counter and 8-bit/2-bit
// counter), directed scenarios followed by random traffic, compared against
// an arithmetic reference model of each channel.
module tb_accum_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  accum_bank_if #(.NCH(2), .WIDTH(32), .CNT_W(8)) if_a ();
  accum_bank_if #(.NCH(2), .WIDTH(8),  .CNT_W(2)) if_b ();

  accum_bank #(.NCH(2), .WIDTH(32), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  accum_bank #(.NCH(2), .WIDTH(8),  .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  int checks = 0;
  int failures = 0;

  // Reference state per channel, held as plain integers.
  logic [63:0] ma_acc[2], ma_ovf[2], ma_cnt[2];
  logic [63:0] mb_acc[2], mb_ovf[2], mb_cnt[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One accepted-edge of a channel, written from the behavioural rules.
  task automatic mstep(input int w, input int cw, input logic sat, input logic v,
                       input logic c, input logic [63:0] din,
                       inout logic [63:0] acc, inout logic [63:0] ovf, inout logic [63:0] cnt);
    logic [63:0] lim, cmax, s;
    lim  = (64'd1 << w) - 1;
    cmax = (64'd1 << cw) - 1;
    if (c) begin
      acc = v ? din : 64'd0;
      cnt = v ? 64'd1 : 64'd0;
      ovf = 64'd0;
    end else if (v) begin
      s = acc + din;
      if (s > lim) begin
        ovf = 64'd1;
        acc = sat ? lim : s - (lim + 1);
      end else begin
        acc = s;
      end
      cnt = (cnt < cmax) ? cnt + 1 : cmax;
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      ma_acc[ch] = 0; ma_ovf[ch] = 0; ma_cnt[ch] = 0;
      mb_acc[ch] = 0; mb_ovf[ch] = 0; mb_cnt[ch] = 0;
    end
  endtask

  task automatic set_idle();
    if_a.sat_mode = 1'b0; if_a.in_valid = '0; if_a.accum_in = '0; if_a.clear = '0; if_a.bypass = '0;
    if_b.sat_mode = 1'b0; if_b.in_valid = '0; if_b.accum_in = '0; if_b.clear = '0; if_b.bypass = '0;
  endtask

  // Called just after an edge with new inputs applied: checks bypass_out,
  // lets the next edge happen, advances the model and checks the registers.
  task automatic tick();
    logic [63:0] e, t_acc, t_ovf, t_cnt;
    #1;
    for (int ch = 0; ch < 2; ch++) begin
      e = if_a.bypass[ch] ? 64'(if_a.accum_in[ch*32 +: 32]) : ma_acc[ch];
      chk($sformatf("a_byp%0d", ch), 64'(if_a.bypass_out[ch*32 +: 32]), e);
      e = if_b.bypass[ch] ? 64'(if_b.accum_in[ch*8 +: 8]) : mb_acc[ch];
      chk($sformatf("b_byp%0d", ch), 64'(if_b.bypass_out[ch*8 +: 8]), e);
    end
    @(posedge clk);
    #1;
    for (int ch = 0; ch < 2; ch++) begin
      t_acc = ma_acc[ch]; t_ovf = ma_ovf[ch]; t_cnt = ma_cnt[ch];
      mstep(32, 8, if_a.sat_mode, if_a.in_valid[ch], if_a.clear[ch],
            64'(if_a.accum_in[ch*32 +: 32]), t_acc, t_ovf, t_cnt);
      ma_acc[ch] = t_acc; ma_ovf[ch] = t_ovf; ma_cnt[ch] = t_cnt;
      t_acc = mb_acc[ch]; t_ovf = mb_ovf[ch]; t_cnt = mb_cnt[ch];
      mstep(8, 2, if_b.sat_mode, if_b.in_valid[ch], if_b.clear[ch],
            64'(if_b.accum_in[ch*8 +: 8]), t_acc, t_ovf, t_cnt);
      mb_acc[ch] = t_acc; mb_ovf[ch] = t_ovf; mb_cnt[ch] = t_cnt;

      chk($sformatf("a_acc%0d", ch), 64'(if_a.accum_out[ch*32 +: 32]), ma_acc[ch]);
      chk($sformatf("a_ovf%0d", ch), 64'(if_a.ovf[ch]), ma_ovf[ch]);
      chk($sformatf("a_cnt%0d", ch), 64'(if_a.count[ch*8 +: 8]), ma_cnt[ch]);
      chk($sformatf("b_acc%0d", ch), 64'(if_b.accum_out[ch*8 +: 8]), mb_acc[ch]);
      chk($sformatf("b_ovf%0d", ch), 64'(if_b.ovf[ch]), mb_ovf[ch]);
      chk($sformatf("b_cnt%0d", ch), 64'(if_b.count[ch*2 +: 2]), mb_cnt[ch]);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_acc"}, 64'(if_a.accum_out), 64'd0);
    chk({tag, "_a_ovf"}, 64'(if_a.ovf), 64'd0);
    chk({tag, "_a_cnt"}, 64'(if_a.count), 64'd0);
    chk({tag, "_b_acc"}, 64'(if_b.accum_out), 64'd0);
    chk({tag, "_b_ovf"}, 64'(if_b.ovf), 64'd0);
    chk({tag, "_b_cnt"}, 64'(if_b.count), 64'd0);
  endtask

  initial begin
    int q33[4];
    int q38[5];
    logic [7:0] rb;
    q33 = '{0, 5, 15, 30};
    q38 = '{1, 2, 3, 3, 3};

    // Reset state, including bypass_out while held in reset.
    set_idle();
    model_reset();
    if_a.bypass = 2'b01;
    if_a.accum_in[31:0] = 32'h1234_5678;
    if_a.accum_in[63:32] = 32'h0000_0099;
    #1;
    chk_all_zero("rst");
    chk("rst_byp_a0", 64'(if_a.bypass_out[31:0]), 64'h1234_5678);
    chk("rst_byp_a1", 64'(if_a.bypass_out[63:32]), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all_zero("rst_held");
    rst_n = 1'b1;
    set_idle();

    // Channel 0 running sum, channel 1 idle.
    if_a.in_valid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      if_a.accum_in[31:0] = 32'(i * 5);
      tick();
      chk("q33_acc0", 64'(if_a.accum_out[31:0]), 64'(q33[i]));
      chk("q33_acc1", 64'(if_a.accum_out[63:32]), 64'd0);
    end

    // Bypass shows the sample while accumulation continues underneath.
    if_a.bypass = 2'b01;
    if_a.accum_in[31:0] = 32'd42;
    #1;
    chk("q37_byp_on", 64'(if_a.bypass_out[31:0]), 64'd42);
    tick();
    chk("q37_acc", 64'(if_a.accum_out[31:0]), 64'd72);
    if_a.bypass = 2'b00;
    if_a.in_valid = 2'b00;
    #1;
    chk("q37_byp_off", 64'(if_a.bypass_out[31:0]), 64'd72);

    // 8-bit wrap overflow.
    set_idle();
    if_b.clear = 2'b01; if_b.in_valid = 2'b01; if_b.accum_in[7:0] = 8'd250;
    tick();
    if_b.clear = 2'b00; if_b.accum_in[7:0] = 8'd10;
    tick();
    chk("q34_acc", 64'(if_b.accum_out[7:0]), 64'd4);
    chk("q34_ovf", 64'(if_b.ovf[0]), 64'd1);
    if_b.accum_in[7:0] = 8'd1;
    tick();
    chk("q34_acc2", 64'(if_b.accum_out[7:0]), 64'd5);
    chk("q34_ovf2", 64'(if_b.ovf[0]), 64'd1);

    // 8-bit saturating overflow.
    if_b.sat_mode = 1'b1;
    if_b.clear = 2'b01; if_b.accum_in[7:0] = 8'd250;
    tick();
    if_b.clear = 2'b00; if_b.accum_in[7:0] = 8'd10;
    tick();
    chk("q35_acc", 64'(if_b.accum_out[7:0]), 64'd255);
    chk("q35_ovf", 64'(if_b.ovf[0]), 64'd1);
    if_b.accum_in[7:0] = 8'd3;
    tick();
    chk("q35_acc2", 64'(if_b.accum_out[7:0]), 64'd255);

    // Build accum=100, ovf=1, count=9 on a channel 1, then clear+sample.
    set_idle();
    if_a.clear = 2'b10; if_a.in_valid = 2'b10; if_a.accum_in[63:32] = 32'hFFFF_FF00;
    tick();
    if_a.clear = 2'b00; if_a.accum_in[63:32] = 32'h0000_0164;
    tick();
    if_a.accum_in[63:32] = 32'd0;
    for (int i = 0; i < 7; i++) tick();
    chk("q36_pre_acc", 64'(if_a.accum_out[63:32]), 64'd100);
    chk("q36_pre_ovf", 64'(if_a.ovf[1]), 64'd1);
    chk("q36_pre_cnt", 64'(if_a.count[15:8]), 64'd9);
    if_a.clear = 2'b10; if_a.accum_in[63:32] = 32'd7;
    tick();
    chk("q36_acc", 64'(if_a.accum_out[63:32]), 64'd7);
    chk("q36_cnt", 64'(if_a.count[15:8]), 64'd1);
    chk("q36_ovf", 64'(if_a.ovf[1]), 64'd0);

    // 2-bit counter saturation.
    set_idle();
    if_b.clear = 2'b10;
    tick();
    if_b.clear = 2'b00; if_b.in_valid = 2'b10; if_b.accum_in[15:8] = 8'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("q38_cnt", 64'(if_b.count[3:2]), 64'(q38[i]));
    end

    // Asynchronous reset between edges, held across an edge with valid samples.
    if_b.bypass = 2'b10; if_b.in_valid = 2'b11; if_b.accum_in = 16'hA53C;
    if_a.in_valid = 2'b11; if_a.accum_in = 64'h0000_0011_0000_0022;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all_zero("arst");
    chk("arst_byp_b1", 64'(if_b.bypass_out[15:8]), 64'hA5);
    chk("arst_byp_b0", 64'(if_b.bypass_out[7:0]), 64'd0);
    @(posedge clk);
    #1;
    chk_all_zero("arst_edge");
    #1;
    rst_n = 1'b1;
    tick();
    chk("arst_first_b1", 64'(if_b.accum_out[15:8]), 64'hA5);
    chk("arst_first_cnt", 64'(if_b.count[3:2]), 64'd1);

    // Random traffic on both banks.
    for (int n = 0; n < 400; n++) begin
      if (n % 23 == 0) begin
        if_a.sat_mode = 1'($urandom);
        if_b.sat_mode = 1'($urandom);
      end
      for (int ch = 0; ch < 2; ch++) begin
        if_a.in_valid[ch] = ($urandom_range(0, 3) != 0);
        if_a.clear[ch]    = ($urandom_range(0, 15) == 0);
        if_a.bypass[ch]   = ($urandom_range(0, 3) == 0);
        if_a.accum_in[ch*32 +: 32] = ($urandom_range(0, 3) == 0) ?
                                     32'hF000_0000 | 32'($urandom) : 32'($urandom_range(0, 100000));
        if_b.in_valid[ch] = ($urandom_range(0, 3) != 0);
        if_b.clear[ch]    = ($urandom_range(0, 11) == 0);
        if_b.bypass[ch]   = ($urandom_range(0, 3) == 0);
        rb = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 40));
        if_b.accum_in[ch*8 +: 8] = rb;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
